fetch_unit: RTL and testbench

Instruction fetch stage: owns the PC, issues one instruction read at a time on a valid/ready memory port, and delivers each fetched pc/instruction pair to the decode pipeline register through a one-cycle write-enable strobe. It is the producer on the fetch-to-decode interface. Downstream stall holds the delivered instruction, and a redirect from execute cancels anything in flight.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time on a
// valid/ready memory port, and hands each fetched pc/instruction pair to the
// decode register with a one-cycle write-enable strobe. Redirects cancel
// anything in flight; a bad read response parks the unit until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        ifu_arvalid_o,
    output logic [31:0] ifu_araddr_o,
    input  logic        ifu_arready_i,
    input  logic        ifu_rvalid_i,
    input  logic [31:0] ifu_rdata_i,
    input  logic [1:0]  ifu_rresp_i,
    output logic        ifu_rready_o,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        we_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        fetch_err_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        HOLD = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] r_pc_out;
    logic        r_kill;
    logic [31:0] r_redir_pc;
    logic        r_fetch_err;
    logic        r_arvalid;
    logic        r_rready;

    // Redirect targets are always word aligned before use.
    logic [31:0] w_target;
    assign w_target = {redirect_pc_i[31:2], 2'b00};

    // Fetch FSM: PC, handshake flags, delivery buffer and kill bookkeeping.
    // NOTE: every register here uses <= so all updates see the pre-edge
    // values; mixing in blocking assignments would make results depend on
    // statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_inst_buf  <= 32'h0;
            r_pc_out    <= RESET_PC;
            r_kill      <= 1'b0;
            r_redir_pc  <= 32'h0;
            r_fetch_err <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (redirect_i) begin
                        r_pc <= w_target;
                    end
                    r_state   <= ADDR;
                    r_arvalid <= 1'b1;
                end

                ADDR: begin
                    // The request stays untouched; a redirect only arms kill.
                    if (redirect_i) begin
                        r_kill     <= 1'b1;
                        r_redir_pc <= w_target;
                    end
                    if (ifu_arready_i) begin
                        r_state   <= DATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end

                DATA: begin
                    if (ifu_rvalid_i) begin
                        r_rready <= 1'b0;
                        if (r_kill || redirect_i) begin
                            // Killed response: data and error both dropped;
                            // a redirect arriving this cycle is the latest.
                            r_kill    <= 1'b0;
                            r_pc      <= redirect_i ? w_target : r_redir_pc;
                            r_state   <= ADDR;
                            r_arvalid <= 1'b1;
                        end else if (ifu_rresp_i != 2'b00) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= ERR;
                        end else begin
                            r_inst_buf <= ifu_rdata_i;
                            r_pc_out   <= r_pc;
                            r_state    <= HOLD;
                        end
                    end else if (redirect_i) begin
                        r_kill     <= 1'b1;
                        r_redir_pc <= w_target;
                    end
                end

                HOLD: begin
                    if (redirect_i) begin
                        r_pc      <= w_target;
                        r_state   <= ADDR;
                        r_arvalid <= 1'b1;
                    end else if (!stall_i) begin
                        r_pc      <= r_pc + 32'd4;
                        r_state   <= ADDR;
                        r_arvalid <= 1'b1;
                    end
                end

                ERR: begin
                    r_state <= ERR;
                end

                default: begin
                    r_state   <= IDLE;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    // Delivery strobe: decode takes the held instruction when it is free
    // and no redirect is dropping it.
    // NOTE: this is the one output that must react within the cycle to
    // stall_i/redirect_i, so it is decoded from the registered state rather
    // than registered itself; every path is assigned, so no latch forms.
    always_comb begin
        we_o = 1'b0;
        if (r_state == HOLD) begin
            we_o = !stall_i && !redirect_i;
        end
    end

    assign ifu_arvalid_o = r_arvalid;
    assign ifu_araddr_o  = r_pc;
    assign ifu_rready_o  = r_rready;
    assign pc_o          = r_pc_out;
    assign inst_o        = r_inst_buf;
    assign fetch_err_o   = r_fetch_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a table of fetch transactions with
// chosen memory latencies and stalls, followed by hand-written sequences for
// redirects, PC wrap, error responses and asynchronous reset.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        ifu_arvalid_o;
    logic [31:0] ifu_araddr_o;
    logic        ifu_arready_i;
    logic        ifu_rvalid_i;
    logic [31:0] ifu_rdata_i;
    logic [1:0]  ifu_rresp_i;
    logic        ifu_rready_o;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        we_o;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        fetch_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int          ar_wait;
        int          r_wait;
        int          stall_n;
        logic [31:0] data;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[6];

    fetch_unit #(.RESET_PC(32'h8000_0000)) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_arvalid_o (ifu_arvalid_o),
        .ifu_araddr_o  (ifu_araddr_o),
        .ifu_arready_i (ifu_arready_i),
        .ifu_rvalid_i  (ifu_rvalid_i),
        .ifu_rdata_i   (ifu_rdata_i),
        .ifu_rresp_i   (ifu_rresp_i),
        .ifu_rready_o  (ifu_rready_o),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .we_o          (we_o),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .fetch_err_o   (fetch_err_o)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge, return all stimulus to idle, settle.
    task automatic step();
        @(negedge clock);
        ifu_arready_i = 1'b0;
        ifu_rvalid_i  = 1'b0;
        ifu_rdata_i   = 32'h0;
        ifu_rresp_i   = 2'b00;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        cyc++;
        #1;
    endtask

    // One complete fetch with the given memory latencies and decode stall.
    // Ends one cycle after the we_o pulse.
    task automatic do_fetch(input int ar_wait, input int r_wait, input int stall_n,
                            input logic [31:0] data, input logic [31:0] exp_pc,
                            output int we_cyc);
        int start;
        int guard;
        guard  = 0;
        we_cyc = 0;
        while (!ifu_arvalid_o && guard < 20) begin
            step();
            guard++;
        end
        if (!ifu_arvalid_o) begin
            check("arvalid_timeout", ifu_arvalid_o, 1);
            return;
        end
        start = cyc;
        for (int k = 0; k < ar_wait; k++) begin
            check("arvalid_wait", ifu_arvalid_o, 1);
            check("araddr_wait", ifu_araddr_o, exp_pc);
            check("rready_in_addr", ifu_rready_o, 0);
            step();
        end
        ifu_arready_i = 1'b1;
        check("araddr", ifu_araddr_o, exp_pc);
        check("rready_in_addr", ifu_rready_o, 0);
        step();
        for (int k = 0; k < r_wait; k++) begin
            check("rready_wait", ifu_rready_o, 1);
            check("arvalid_in_data", ifu_arvalid_o, 0);
            check("we_in_data", we_o, 0);
            step();
        end
        ifu_rvalid_i = 1'b1;
        ifu_rdata_i  = data;
        check("rready", ifu_rready_o, 1);
        step();
        for (int k = 0; k < stall_n; k++) begin
            stall_i = 1'b1;
            #1;
            check("we_stalled", we_o, 0);
            check("pc_o_stalled", pc_o, exp_pc);
            check("inst_o_stalled", inst_o, data);
            check("rready_in_hold", ifu_rready_o, 0);
            step();
        end
        check("we", we_o, 1);
        check("pc_o", pc_o, exp_pc);
        check("inst_o", inst_o, data);
        check("latency", cyc - start, 2 + ar_wait + r_wait + stall_n);
        we_cyc = cyc;
        step();
    endtask

    initial begin
        int we_cyc;
        int prev_we;

        vecs[0] = '{0, 0, 0, 32'h0000_0013, 32'h8000_0000};
        vecs[1] = '{0, 0, 0, 32'h0000_0013, 32'h8000_0004};
        vecs[2] = '{0, 0, 0, 32'h0000_0013, 32'h8000_0008};
        vecs[3] = '{4, 2, 0, 32'hDEAD_BEEF, 32'h8000_000C};
        vecs[4] = '{0, 0, 5, 32'h1234_5678, 32'h8000_0010};
        vecs[5] = '{1, 3, 2, 32'hA5A5_A5A5, 32'h8000_0014};

        reset         = 1'b0;
        ifu_arready_i = 1'b0;
        ifu_rvalid_i  = 1'b0;
        ifu_rdata_i   = 32'h0;
        ifu_rresp_i   = 2'b00;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        repeat (3) step();

        // Reset state.
        check("rst_arvalid", ifu_arvalid_o, 0);
        check("rst_rready", ifu_rready_o, 0);
        check("rst_we", we_o, 0);
        check("rst_pc_o", pc_o, 32'h8000_0000);
        check("rst_inst_o", inst_o, 32'h0);
        check("rst_err", fetch_err_o, 0);
        reset = 1'b1;
        #1;
        check("idle_arvalid", ifu_arvalid_o, 0);

        // Table of fetch transactions.
        prev_we = 0;
        for (int i = 0; i < 6; i++) begin
            do_fetch(vecs[i].ar_wait, vecs[i].r_wait, vecs[i].stall_n,
                     vecs[i].data, vecs[i].exp_pc, we_cyc);
            if (i == 1 || i == 2) check("we_spacing", we_cyc - prev_we, 3);
            prev_we = we_cyc;
        end

        // Redirect in DATA; response arrives two cycles later and is dropped.
        check("pre_redir_araddr", ifu_araddr_o, 32'h8000_0018);
        ifu_arready_i = 1'b1;
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h8000_1002;
        #1;
        check("redir_data_rready", ifu_rready_o, 1);
        check("redir_data_we", we_o, 0);
        step();
        check("kill_wait_rready", ifu_rready_o, 1);
        step();
        ifu_rvalid_i = 1'b1;
        ifu_rdata_i  = 32'hBAD0_BAD0;
        check("killed_we", we_o, 0);
        step();
        check("redir_arvalid", ifu_arvalid_o, 1);
        check("redir_araddr", ifu_araddr_o, 32'h8000_1000);
        check("redir_we", we_o, 0);
        do_fetch(0, 0, 0, 32'h1111_1111, 32'h8000_1000, we_cyc);

        // Redirect plus stall in HOLD, to a target that then wraps.
        ifu_arready_i = 1'b1;
        check("hold_seq_araddr", ifu_araddr_o, 32'h8000_1004);
        step();
        ifu_rvalid_i = 1'b1;
        ifu_rdata_i  = 32'h2222_2222;
        step();
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        #1;
        check("hold_redir_we", we_o, 0);
        check("hold_redir_pc_o", pc_o, 32'h8000_1004);
        check("hold_redir_inst_o", inst_o, 32'h2222_2222);
        step();
        check("hold_redir_araddr", ifu_araddr_o, 32'hFFFF_FFFC);
        do_fetch(0, 0, 0, 32'h0000_0033, 32'hFFFF_FFFC, we_cyc);
        check("wrap_arvalid", ifu_arvalid_o, 1);
        check("wrap_araddr", ifu_araddr_o, 32'h0);
        do_fetch(0, 0, 0, 32'h0000_0044, 32'h0, we_cyc);

        // Redirect in ADDR while arready is late; killed response has an error.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0100;
        #1;
        check("addr_redir_araddr", ifu_araddr_o, 32'h4);
        step();
        check("addr_hold_arvalid", ifu_arvalid_o, 1);
        check("addr_hold_araddr", ifu_araddr_o, 32'h4);
        ifu_arready_i = 1'b1;
        step();
        ifu_rvalid_i = 1'b1;
        ifu_rresp_i  = 2'b10;
        ifu_rdata_i  = 32'hEEEE_EEEE;
        step();
        check("killed_err_flag", fetch_err_o, 0);
        check("killed_err_araddr", ifu_araddr_o, 32'h100);
        check("killed_err_arvalid", ifu_arvalid_o, 1);
        do_fetch(0, 0, 0, 32'h0000_0055, 32'h100, we_cyc);

        // Live error response: parks in ERR, redirects ignored.
        ifu_arready_i = 1'b1;
        step();
        ifu_rvalid_i = 1'b1;
        ifu_rresp_i  = 2'b10;
        ifu_rdata_i  = 32'h0000_0077;
        step();
        check("err_flag", fetch_err_o, 1);
        check("err_inst_o", inst_o, 32'h55);
        for (int k = 0; k < 4; k++) begin
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h0000_0300;
            ifu_rvalid_i  = 1'b1;
            #1;
            check("err_arvalid", ifu_arvalid_o, 0);
            check("err_rready", ifu_rready_o, 0);
            check("err_we", we_o, 0);
            check("err_sticky", fetch_err_o, 1);
            step();
        end

        // Reset to recover, then redirect while in IDLE.
        reset = 1'b0;
        #1;
        check("rst_clears_err", fetch_err_o, 0);
        step();
        reset = 1'b1;
        check("idle2_arvalid", ifu_arvalid_o, 0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        step();
        do_fetch(0, 0, 0, 32'h0000_0066, 32'h200, we_cyc);

        // Asynchronous reset in the middle of DATA.
        ifu_arready_i = 1'b1;
        step();
        check("pre_rst_rready", ifu_rready_o, 1);
        reset = 1'b0;
        #1;
        check("async_rready", ifu_rready_o, 0);
        check("async_arvalid", ifu_arvalid_o, 0);
        check("async_pc_o", pc_o, 32'h8000_0000);
        check("async_inst_o", inst_o, 32'h0);
        check("async_err", fetch_err_o, 0);
        step();
        step();
        reset = 1'b1;
        do_fetch(0, 0, 0, 32'h0000_0013, 32'h8000_0000, we_cyc);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
